rr_arbiter_5port: RTL and testbench
===================================

Name: rr_arbiter_5port

Overview:
- Round-robin arbiter with packet lock for one router output port.
- Shares the port among the N, S, W, E and Local inputs.
- Drives the select of the 5:1 output mux with the same encoding the mux uses: N=000, S=001, W=010, E=011, L=100.
- Holds a grant for the length of a wormhole packet, then rotates priority.

Parameters:
TIMEOUT_CYCLES, 16, idle cycles in LOCKED before a forced release (used only with RR_ARB_TIMEOUT_EN); legal range 2..255.
PTR_RESET, 0, index of the highest-priority port after reset (0=N, 1=S, 2=W, 3=E, 4=L).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
req_i  input  5  per-port request; bit0=N, bit1=S, bit2=W, bit3=E, bit4=L.
xfer_i  input  1  a flit from the granted port was accepted downstream this cycle.
tail_i  input  1  the flit transferred this cycle is the packet tail; only meaningful when xfer_i=1.
grant_o  output  5  one-hot grant, same bit order as req_i; all-zero when idle.
sel_o  output  3  encoded mux select for the granted port.
valid_o  output  1  a grant is active (OR of grant_o).
timeout_o  output  1  one-cycle pulse on forced release; exists only with RR_ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values:
  - grant_o=00000, sel_o=000, valid_o=0, timeout_o=0.
  - State=IDLE, priority pointer=PTR_RESET, timeout counter=0.
  - Assertion of rst_ni takes effect immediately, including mid-packet.
- State machine has two states, IDLE and LOCKED. All outputs are registered.
- IDLE:
  - If req_i=0, stay in IDLE; outputs are unchanged.
  - If req_i≠0, select the first set bit scanning upward from the pointer, mod 5.
  - On the next edge: grant_o=onehot(winner), sel_o=enc(winner), valid_o=1, go to LOCKED.
  - Latency from req_i to grant_o is 1 cycle.
- LOCKED:
  - Grant is held regardless of req_i; a dropped request does not release it.
  - Only xfer_i&tail_i releases the grant.
  - On a cycle with xfer_i=1 and tail_i=1:
    - Next edge: grant_o=0, valid_o=0, pointer=(winner+1) mod 5, go to IDLE.
  - sel_o keeps its last value while idle; the mux output is qualified by valid_o.
  - xfer_i=1 with tail_i=0 keeps the lock and changes nothing.
- Back-to-back packets: IDLE always lasts at least one cycle, so there is exactly one bubble between packets. The new winner is chosen against the already-rotated pointer.
- Pointer wrap: after L (4) the pointer becomes N (0).
- Single requester: the same port may win again after its own tail; it still sees the one-cycle bubble.
- xfer_i and tail_i are ignored in IDLE.
- Invariants:
  - grant_o is always zero or one-hot.
  - sel_o is never 101, 110 or 111.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in LOCKED. It clears on any xfer_i and otherwise increments.
  - When the counter reaches TIMEOUT_CYCLES-1 with no xfer_i, the next edge releases the grant, pulses timeout_o=1 for one cycle, rotates the pointer as for a tail, clears the counter and enters IDLE.
  - The counter is 0 in IDLE.
  - If xfer_i&tail_i arrive in the same cycle as the timeout, a normal release occurs with timeout_o=0.
- Undefined:
  - No counter is built and timeout_o is not present.
  - The lock is held indefinitely until a tail transfer.

Test Plan:
1. Hold rst_ni=0, then release. Expect grant_o=00000, sel_o=000, valid_o=0. Then req_i=10000 gives grant_o=10000, sel_o=100, valid_o=1 exactly one cycle later.
2. req_i=11111 held, single-flit packets (xfer_i=tail_i=1 each locked cycle). Expect sel_o sequence 000,001,010,011,100,000 with valid_o=0 one cycle between each grant.
3. Grant W (req_i=00100), then switch req_i to 01001 and send 3 flits with tail on the third. Expect grant_o=00100 held through the third xfer, then IDLE, then E (01000) is granted because the pointer is at 3.
4. In LOCKED, pull xfer_i=1 with tail_i=0 for 4 cycles and drop req_i to 0. Expect grant unchanged. A tail then releases, and req_i=0 keeps the block in IDLE with valid_o=0.
5. Assert rst_ni=0 asynchronously mid-packet, between clock edges, with grant_o=00010. Expect grant_o=00000 and valid_o=0 before the next edge, and pointer=PTR_RESET after release.
6. With RR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, lock N and send no xfer_i. Expect timeout_o=1 for one cycle 16 cycles after the grant, grant_o=00000, and S prioritised next. Also check that an xfer on cycle 10 restarts the count.

Source files
------------

// File: rtl/rr_arbiter_5port.sv
// -----------------------------------------------------------------------------
// rr_arbiter_5port
//
// Round-robin arbiter with wormhole packet lock for one router output port.
// The five inputs (N, S, W, E, Local) compete for the port. Once a port wins,
// the grant is held until the packet tail has been transferred. After that,
// priority rotates to the port just after the winner.
//
// Optional build macro: RR_ARB_TIMEOUT_EN
//   When defined, an 8-bit idle counter runs while a grant is locked. If no
//   flit moves for TIMEOUT_CYCLES cycles, the lock is released and timeout_o
//   pulses for one cycle. When undefined, no counter is built, timeout_o does
//   not exist, and a lock is held until a tail transfer.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles in LOCKED before a forced release (2..255);
//                   only used with RR_ARB_TIMEOUT_EN
//   PTR_RESET       highest-priority port after reset (0=N,1=S,2=W,3=E,4=L)
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   req_i      per-port request, bit0=N bit1=S bit2=W bit3=E bit4=L
//   xfer_i     a flit from the granted port was accepted downstream
//   tail_i     the flit transferred this cycle is the packet tail
//   grant_o    one-hot grant (all zero when idle)
//   sel_o      encoded select for the 5:1 output mux (N=0 .. L=4)
//   valid_o    a grant is active
//   timeout_o  one-cycle pulse on a forced release (RR_ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module rr_arbiter_5port #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int PTR_RESET      = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] req_i,
  input  logic       xfer_i,
  input  logic       tail_i,
  output logic [4:0] grant_o,
  output logic [2:0] sel_o,
`ifdef RR_ARB_TIMEOUT_EN
  output logic       valid_o,
  output logic       timeout_o
`else
  output logic       valid_o
`endif
);

  // Elaboration-time parameter sanity checks.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_arbiter_5port: TIMEOUT_CYCLES must be in 2..255");
  end
  if (PTR_RESET < 0 || PTR_RESET > 4) begin : g_bad_ptr
    $error("rr_arbiter_5port: PTR_RESET must be in 0..4");
  end

  localparam logic [2:0] PTR_INIT = 3'(PTR_RESET);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] grant_q, grant_d;
  logic [2:0] sel_q,   sel_d;
  logic       valid_q, valid_d;
  logic [2:0] ptr_q,   ptr_d;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // ---------------------------------------------------------------------------
  // Winner search: first set request scanning upward from ptr_q, modulo 5.
  // ---------------------------------------------------------------------------
  logic       win_found;
  logic [2:0] win_idx;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= 5) begin
        idx = idx - 5;
      end
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = 3'(idx);
      end
    end
  end

  // Port following the current holder; sel_q names the holder while LOCKED.
  logic [2:0] ptr_after_holder;
  assign ptr_after_holder = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d     = 8'd0;
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // xfer_i/tail_i are meaningless here; only requests matter.
        if (win_found) begin
          grant_d = 5'(5'b00001 << win_idx);
          sel_d   = win_idx;
          valid_d = 1'b1;
          state_d = LOCKED;
        end
      end

      LOCKED: begin
        if (xfer_i && tail_i) begin
          // Normal end of packet; takes precedence over a coincident timeout.
          grant_d = 5'b00000;
          valid_d = 1'b0;
          ptr_d   = ptr_after_holder;
          state_d = IDLE;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (xfer_i) begin
          cnt_d = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          // Stalled too long: force release exactly like a tail would.
          grant_d   = 5'b00000;
          valid_d   = 1'b0;
          ptr_d     = ptr_after_holder;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
        grant_d = 5'b00000;
        valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= 5'b00000;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      ptr_q   <= PTR_INIT;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

  assign grant_o = grant_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_rr_arbiter_5port.sv
module tb_rr_arbiter_5port;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic       xfer;
  logic       tail;
  logic [4:0] grant;
  logic [2:0] sel;
  logic       valid;
`ifdef RR_ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int checks;
  int failures;

  rr_arbiter_5port #(
    .TIMEOUT_CYCLES(16),
    .PTR_RESET(0)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .xfer_i   (xfer),
    .tail_i   (tail),
    .grant_o  (grant),
    .sel_o    (sel),
`ifdef RR_ARB_TIMEOUT_EN
    .valid_o  (valid),
    .timeout_o(timeout)
`else
    .valid_o  (valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 5'b0;
    xfer  = 1'b0;
    tail  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 5'b0;
    xfer  = 1'b0;
    tail  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (grant !== 5'b00000 || sel !== 3'b000 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: grant=%b sel=%b valid=%b, want 00000/000/0", grant, sel, valid);
    end
    rst_n = 1'b1;
    step();
    req = 5'b10000;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_early_grant: valid=%b want 0", valid);
    end
    step();
    checks++;
    if (grant !== 5'b10000 || sel !== 3'b100 || valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant_L: grant=%b sel=%b valid=%b, want 10000/100/1", grant, sel, valid);
    end
    $display("test_reset: grant=%b sel=%b valid=%b", grant, sel, valid);
  endtask

  task automatic test_rotation();
    logic [2:0] exp_sel [6];
    exp_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    do_reset();
    req  = 5'b11111;
    xfer = 1'b1;
    tail = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || sel !== exp_sel[i] || grant !== 5'(5'b00001 << exp_sel[i])) begin
        failures++;
        $display("FAIL rotation_grant[%0d]: grant=%b sel=%b valid=%b, want sel=%b valid=1", i, grant, sel, valid, exp_sel[i]);
      end
      $display("test_rotation: packet %0d grant=%b sel=%b", i, grant, sel);
      step();
      checks++;
      if (valid !== 1'b0 || grant !== 5'b00000) begin
        failures++;
        $display("FAIL rotation_bubble[%0d]: grant=%b valid=%b, want 00000/0", i, grant, valid);
      end
    end
    req  = 5'b0;
    xfer = 1'b0;
    tail = 1'b0;
  endtask

  task automatic test_multiflit();
    do_reset();
    req = 5'b00100;
    step();
    checks++;
    if (grant !== 5'b00100 || sel !== 3'b010) begin
      failures++;
      $display("FAIL multiflit_grant_W: grant=%b sel=%b, want 00100/010", grant, sel);
    end
    req  = 5'b01001;
    xfer = 1'b1;
    tail = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (grant !== 5'b00100 || valid !== 1'b1) begin
        failures++;
        $display("FAIL multiflit_hold[%0d]: grant=%b valid=%b, want 00100/1", i, grant, valid);
      end
    end
    tail = 1'b1;
    step();
    xfer = 1'b0;
    tail = 1'b0;
    checks++;
    if (grant !== 5'b00000 || valid !== 1'b0) begin
      failures++;
      $display("FAIL multiflit_release: grant=%b valid=%b, want 00000/0", grant, valid);
    end
    step();
    checks++;
    if (grant !== 5'b01000 || sel !== 3'b011) begin
      failures++;
      $display("FAIL multiflit_next_E: grant=%b sel=%b, want 01000/011", grant, sel);
    end
    $display("test_multiflit: next grant=%b sel=%b", grant, sel);
    req = 5'b0;
  endtask

  task automatic test_hold_and_idle();
    do_reset();
    req = 5'b00010;
    step();
    req  = 5'b00000;
    xfer = 1'b1;
    tail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (grant !== 5'b00010 || sel !== 3'b001 || valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_no_tail[%0d]: grant=%b sel=%b valid=%b, want 00010/001/1", i, grant, sel, valid);
      end
    end
    tail = 1'b1;
    step();
    xfer = 1'b0;
    tail = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (grant !== 5'b00000 || valid !== 1'b0 || sel !== 3'b001) begin
        failures++;
        $display("FAIL idle_no_req[%0d]: grant=%b sel=%b valid=%b, want 00000/001/0", i, grant, sel, valid);
      end
    end
    $display("test_hold_and_idle: grant=%b sel=%b valid=%b", grant, sel, valid);
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 5'b00010;
    step();
    xfer = 1'b1;
    tail = 1'b0;
    checks++;
    if (grant !== 5'b00010) begin
      failures++;
      $display("FAIL async_pre_grant: grant=%b want 00010", grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 5'b00000 || valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_immediate: grant=%b valid=%b, want 00000/0", grant, valid);
    end
    xfer = 1'b0;
    req  = 5'b11111;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (grant !== 5'b00001 || sel !== 3'b000) begin
      failures++;
      $display("FAIL async_ptr_reset: grant=%b sel=%b, want 00001/000", grant, sel);
    end
    $display("test_async_reset: grant=%b sel=%b", grant, sel);
    req = 5'b0;
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 5'b00001;
    step();
    req = 5'b00000;
    for (int i = 1; i < 16; i++) begin
      step();
      checks++;
      if (grant !== 5'b00001 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_early[%0d]: grant=%b timeout=%b, want 00001/0", i, grant, timeout);
      end
    end
    step();
    checks++;
    if (timeout !== 1'b1 || grant !== 5'b00000 || valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire: timeout=%b grant=%b valid=%b, want 1/00000/0", timeout, grant, valid);
    end
    req = 5'b11111;
    step();
    checks++;
    if (timeout !== 1'b0 || grant !== 5'b00010) begin
      failures++;
      $display("FAIL timeout_next_S: timeout=%b grant=%b, want 0/00010", timeout, grant);
    end
    $display("test_timeout: next grant=%b", grant);

    // An xfer on cycle 10 restarts the idle count.
    do_reset();
    req = 5'b00001;
    step();
    req = 5'b00000;
    for (int i = 1; i < 26; i++) begin
      xfer = (i == 10);
      step();
      checks++;
      if (grant !== 5'b00001 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_restart_hold[%0d]: grant=%b timeout=%b, want 00001/0", i, grant, timeout);
      end
    end
    xfer = 1'b0;
    step();
    checks++;
    if (timeout !== 1'b1 || grant !== 5'b00000) begin
      failures++;
      $display("FAIL timeout_restart_fire: timeout=%b grant=%b, want 1/00000", timeout, grant);
    end
    $display("test_timeout: restart fired timeout=%b", timeout);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 5'b0;
    xfer     = 1'b0;
    tail     = 1'b0;
    test_reset();
    test_rotation();
    test_multiflit();
    test_hold_and_idle();
    test_async_reset();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
